// File: rtl/spike_event_encoder.sv
// Spike-vector to address-event encoder.
// Captures a multi-bit spike vector with its label and timestamp, serialises the
// set bits lowest-first into {channel, label, timestamp} records, and buffers the
// records in a first-word fall-through FIFO with a valid/ready output.
module spike_event_encoder #(
    parameter int unsigned P_CHANNELS   = 8,
    parameter int unsigned P_LABELS     = 4,
    parameter int unsigned P_TS_WIDTH   = 16,
    parameter int unsigned P_FIFO_DEPTH = 16
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic [P_CHANNELS-1:0]             i_test_vector,
    input  logic [P_LABELS-1:0]               i_label,
    input  logic                              i_end_of_epochs,
    output logic                              o_event_valid,
    input  logic                              i_event_ready,
    output logic [$clog2(P_CHANNELS)-1:0]     o_event_addr,
    output logic [P_LABELS-1:0]               o_event_label,
    output logic [P_TS_WIDTH-1:0]             o_event_ts,
    output logic [$clog2(P_FIFO_DEPTH):0]     o_fifo_level,
    output logic                              o_overflow,
    output logic                              o_done
);

    localparam int unsigned AW = $clog2(P_CHANNELS);
    localparam int unsigned PW = $clog2(P_FIFO_DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam int unsigned EW = AW + P_LABELS + P_TS_WIDTH;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StFlush,
        StDone
    } state_e;

    // Free-running timestamp
    logic [P_TS_WIDTH-1:0] ts_q;

    // Control state and capture register
    state_e                state_q;
    logic [P_CHANNELS-1:0] vec_q;
    logic [P_LABELS-1:0]   lab_q;
    logic [P_TS_WIDTH-1:0] cts_q;
    logic                  end_seen_q;
    logic                  overflow_q;
    logic                  done_q;

    // Event FIFO
    logic [EW-1:0]         mem_q [P_FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q;
    logic [PW-1:0]         rd_ptr_q;
    logic [LW-1:0]         level_q;

    // Datapath decode
    logic                  in_nz;
    logic                  pop;
    logic                  push_ok;
    logic                  push;
    logic [P_CHANNELS-1:0] vec_rest;
    logic                  last_push;
    logic                  cap_free;
    logic                  accept;
    logic                  drop;
    logic [AW-1:0]         low_idx;
    logic [EW-1:0]         push_entry;

    // Priority-encode the lowest set bit of the capture register
    always_comb begin
        low_idx = '0;
        for (int i = int'(P_CHANNELS) - 1; i >= 0; i--) begin
            if (vec_q[i]) begin
                low_idx = AW'(i);
            end
        end
    end

    // Push/pop/accept decisions for this edge
    always_comb begin
        in_nz      = |i_test_vector;
        pop        = (level_q != '0) && i_event_ready;
        // A same-edge pop frees a slot even when the FIFO is full
        push_ok    = (level_q < LW'(P_FIFO_DEPTH)) || pop;
        // vec_q is always nonzero while in StScan
        push       = (state_q == StScan) && push_ok;
        vec_rest   = vec_q & (vec_q - 1'b1);
        last_push  = push && (vec_rest == '0);
        // The capture register is free if idle, or if its last bit leaves on this edge
        cap_free   = (state_q == StIdle) || last_push;
        accept     = in_nz && cap_free;
        drop       = in_nz && !cap_free && (state_q != StDone);
        push_entry = {low_idx, lab_q, cts_q};
    end

    // Timestamp counter, wraps silently
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + 1'b1;
        end
    end

    // Control FSM with capture register and sticky status flags
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= StIdle;
            vec_q      <= '0;
            lab_q      <= '0;
            cts_q      <= '0;
            end_seen_q <= 1'b0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            if (i_end_of_epochs && (state_q != StDone)) begin
                end_seen_q <= 1'b1;
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        vec_q   <= i_test_vector;
                        lab_q   <= i_label;
                        cts_q   <= ts_q;
                        state_q <= StScan;
                    end else if (end_seen_q) begin
                        if (level_q == '0) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StFlush;
                        end
                    end
                end
                StScan: begin
                    // Without a push the FIFO is full: hold all remaining bits
                    if (push) begin
                        if (last_push) begin
                            if (accept) begin
                                vec_q <= i_test_vector;
                                lab_q <= i_label;
                                cts_q <= ts_q;
                            end else begin
                                vec_q   <= '0;
                                state_q <= StIdle;
                            end
                        end else begin
                            vec_q <= vec_rest;
                        end
                    end
                end
                StFlush: begin
                    if (level_q == '0) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StDone;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // FIFO storage, pointers and occupancy
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(P_FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_entry;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    assign o_event_valid = (level_q != '0);
    assign {o_event_addr, o_event_label, o_event_ts} = mem_q[rd_ptr_q];
    assign o_fifo_level  = level_q;
    assign o_overflow    = overflow_q;
    assign o_done        = done_q;

endmodule
